memory_access_sequencer: RTL

Sequential memory-access stage controller for the pipelined processor. It decodes memory opcodes into write enable, read enable and address-mux select, then holds them registered for the whole access. It waits for the data memory to acknowledge, stalls the pipeline while waiting, and counts completed accesses. It sits between the EX/MEM pipeline register and the data memory, and its outputs replace the purely combinational memory-access decode.

---
 rtl/memory_access_sequencer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/memory_access_sequencer.sv
// Purpose: registered memory-access stage controller; decodes STORE/LOAD/COPYIN into
//          strobes plus address select, holds them for the whole access, counts completions.
// Latency: accept at edge t, strobes valid from t+1; done_Out pulses one cycle after the
//          ready cycle (minimum access = 2 cycles).
// Backpressure: stall_Out = ACCESS && !memReady_In; upstream holds its instruction meanwhile.
// Ports: clock/reset (async active-low); instruction, instrValid_In, memReady_In in;
//        writeEnable_Out, readEnable_Out, address_Control_Out, stall_Out, done_Out,
//        accessCount_Out, timeout_Out out.
// Optional feature: MEMACC_TIMEOUT_EN adds a per-access wait limit of TIMEOUT_CYCLES.
module memory_access_sequencer #(
  parameter int                  INSTR_W        = 20,
  parameter int                  OPCODE_W       = 4,
  parameter logic [OPCODE_W-1:0] STORE_OP       = 4'b1100,
  parameter logic [OPCODE_W-1:0] COPYIN_OP      = 4'b1111,
  parameter logic [OPCODE_W-1:0] LOAD_OP        = 4'b1101,
  parameter int                  COUNT_W        = 8,
  parameter int                  TIMEOUT_CYCLES = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               instrValid_In,
  input  logic               memReady_In,
  output logic               writeEnable_Out,
  output logic               readEnable_Out,
  output logic [1:0]         address_Control_Out,
  output logic               stall_Out,
  output logic               done_Out,
  output logic [COUNT_W-1:0] accessCount_Out,
  output logic               timeout_Out
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [OPCODE_W-1:0]  opcode_q, opcode_d;
  logic                 we_q, we_d;
  logic                 re_q, re_d;
  logic [1:0]           sel_q, sel_d;
  logic                 done_q, done_d;
  logic [COUNT_W-1:0]   cnt_q, cnt_d;
  logic [OPCODE_W-1:0]  opcode;
  logic [3:0]           dec_new;
  logic [3:0]           dec_held;

  assign opcode = instruction[INSTR_W-1 -: OPCODE_W];

  // Only the opcode field matters here; the operand bits belong to other stages.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instruction[INSTR_W-OPCODE_W-1:0];

  // {write, read, select}; all-zero means "not a memory opcode".
  function automatic logic [3:0] decode(input logic [OPCODE_W-1:0] op);
    logic [3:0] r;
    r = 4'b0000;
    if (op == STORE_OP)       r = 4'b1010;
    else if (op == LOAD_OP)   r = 4'b0111;
    else if (op == COPYIN_OP) r = 4'b0101;
    return r;
  endfunction

  assign dec_new  = decode(opcode);
  // Strobes during ACCESS are re-derived from the latched opcode so they stay constant
  // even though upstream is free to change the instruction bus.
  assign dec_held = decode(opcode_q);

`ifdef MEMACC_TIMEOUT_EN
  localparam int WAIT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_CYCLES - 1);

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              timeout_q, timeout_d;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    we_d     = 1'b0;
    re_d     = 1'b0;
    sel_d    = 2'b00;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
`ifdef MEMACC_TIMEOUT_EN
    wait_d    = wait_q;
    timeout_d = timeout_q;
`endif
    case (state_q)
      IDLE: begin
        if (instrValid_In && (dec_new != 4'b0000)) begin
          state_d              = ACCESS;
          opcode_d             = opcode;
          {we_d, re_d, sel_d}  = dec_new;
`ifdef MEMACC_TIMEOUT_EN
          wait_d    = '0;
          timeout_d = 1'b0;
`endif
        end
      end
      ACCESS: begin
        if (memReady_In) begin
          // Ready beats the wait limit when both land in the same cycle.
          state_d = IDLE;
          done_d  = 1'b1;
          cnt_d   = cnt_q + 1'b1;
        end else begin
          {we_d, re_d, sel_d} = dec_held;
`ifdef MEMACC_TIMEOUT_EN
          if (wait_q == WAIT_LIMIT) begin
            state_d   = IDLE;
            we_d      = 1'b0;
            re_d      = 1'b0;
            sel_d     = 2'b00;
            timeout_d = 1'b1;
          end else begin
            wait_d = wait_q + 1'b1;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      opcode_q <= '0;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
      sel_q    <= 2'b00;
      done_q   <= 1'b0;
      cnt_q    <= '0;
`ifdef MEMACC_TIMEOUT_EN
      wait_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      we_q     <= we_d;
      re_q     <= re_d;
      sel_q    <= sel_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
`ifdef MEMACC_TIMEOUT_EN
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign writeEnable_Out     = we_q;
  assign readEnable_Out      = re_q;
  assign address_Control_Out = sel_q;
  assign done_Out            = done_q;
  assign accessCount_Out     = cnt_q;
  assign stall_Out           = (state_q == ACCESS) && !memReady_In;
`ifdef MEMACC_TIMEOUT_EN
  assign timeout_Out = timeout_q;
`else
  assign timeout_Out = 1'b0;
`endif

endmodule
